// File: rtl/ifmap_batch_ctrl_if.sv
// Shared layer-type encoding and the loader/NOC handshake bundle of the
// ifmap batch controller.
package ifmap_batch_pkg;
  typedef enum logic [1:0] {
    LAYER1 = 2'd0,
    LAYER2 = 2'd1,
    LAYER3 = 2'd2
  } layer_type_e;
endpackage

interface ifmap_batch_if #(
  parameter int NUM_SLOTS = 2,
  parameter int BIDX_W    = 4
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  // Loader side: one request in flight, completed by a load_done pulse.
  logic              load_req;
  logic [SLOT_W-1:0] load_slot;
  logic [BIDX_W-1:0] load_bidx;
  logic              load_done;
  // NOC / PE-array side: slot presentation and retirement.
  logic              free_ifmap_buffer;
  logic              batch_valid;
  logic [SLOT_W-1:0] rd_slot;

  // The controller.
  modport master (
    output load_req, load_slot, load_bidx, batch_valid, rd_slot,
    input  load_done, free_ifmap_buffer
  );

  // The loader and NOC environment.
  modport slave (
    input  load_req, load_slot, load_bidx, batch_valid, rd_slot,
    output load_done, free_ifmap_buffer
  );
endinterface

// File: rtl/ifmap_batch_ctrl.sv
// Producer-side controller for the ifmap buffer ring: issues one batch load
// at a time into the next free slot, presents the oldest filled slot to the
// PE array, retires it on free_ifmap_buffer and pulses layer_done once every
// batch of the layer has been loaded and freed.
module ifmap_batch_ctrl
  import ifmap_batch_pkg::*;
#(
  parameter int NUM_SLOTS  = 2,
  parameter int L1_BATCHES = 8,
  parameter int L2_BATCHES = 1,
  parameter int L3_BATCHES = 1,
  parameter int BIDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  layer_type_e          layer_type_in,
  ifmap_batch_if.master        bus,
  output logic                 layer_done,
  output logic                 err_underflow
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_SLOTS-1:0]   full_q, full_d;
  logic [SLOT_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [SLOT_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [BIDX_W-1:0]      fetched_q, fetched_d;
  logic [BIDX_W-1:0]      freed_q, freed_d;
  logic [BIDX_W-1:0]      total_q, total_d;
  logic                   outstanding_q, outstanding_d;
  logic [SLOT_W-1:0]      load_slot_q, load_slot_d;
  logic [BIDX_W-1:0]      load_bidx_q, load_bidx_d;
  logic                   batch_valid_q, batch_valid_d;
  logic                   layer_done_q, layer_done_d;
  logic                   err_q, err_d;

  logic accept_done;
  logic free_ok;
  logic free_bad;

  function automatic logic [BIDX_W-1:0] batch_count(input layer_type_e t);
    case (t)
      LAYER2:  batch_count = BIDX_W'(L2_BATCHES);
      LAYER3:  batch_count = BIDX_W'(L3_BATCHES);
      default: batch_count = BIDX_W'(L1_BATCHES);
    endcase
  endfunction

  // Next-state, ring bookkeeping and next values of every registered output.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can leave it
    // unassigned, which is what would otherwise infer a latch.
    state_d       = state_q;
    full_d        = full_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fetched_d     = fetched_q;
    freed_d       = freed_q;
    total_d       = total_q;
    outstanding_d = outstanding_q;
    load_slot_d   = load_slot_q;
    load_bidx_d   = load_bidx_q;
    err_d         = err_q;
    layer_done_d  = 1'b0;

    accept_done = outstanding_q && bus.load_done;
    free_ok     = bus.free_ifmap_buffer && (state_q == S_RUN) && full_q[rd_ptr_q];
    free_bad    = bus.free_ifmap_buffer && !free_ok;

    if (start) begin
      // A new layer wins over everything else, including a same-cycle load_done.
      state_d       = S_RUN;
      full_d        = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      fetched_d     = '0;
      freed_d       = '0;
      err_d         = 1'b0;
      total_d       = batch_count(layer_type_in);
      outstanding_d = (total_d != '0);
      load_slot_d   = '0;
      load_bidx_d   = '0;
    end else begin
      // Load completion and free target different slots, so both apply.
      if (accept_done) begin
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = wr_ptr_q + 1'b1;
        fetched_d        = fetched_q + 1'b1;
        outstanding_d    = 1'b0;
      end
      if (free_ok) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = rd_ptr_q + 1'b1;
        freed_d          = freed_q + 1'b1;
      end
      if (free_bad) begin
        err_d = 1'b1;
      end

      case (state_q)
        S_RUN: begin
          if (free_ok && (freed_d == total_q)) begin
            state_d      = S_DONE;
            layer_done_d = 1'b1;
          end else if (!outstanding_q && !full_q[wr_ptr_q] && (fetched_q < total_q)) begin
            outstanding_d = 1'b1;
            load_slot_d   = wr_ptr_q;
            load_bidx_d   = fetched_q;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end

    batch_valid_d = full_d[rd_ptr_d];
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      full_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fetched_q     <= '0;
      freed_q       <= '0;
      total_q       <= '0;
      outstanding_q <= 1'b0;
      load_slot_q   <= '0;
      load_bidx_q   <= '0;
      batch_valid_q <= 1'b0;
      layer_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q       <= state_d;
      full_q        <= full_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fetched_q     <= fetched_d;
      freed_q       <= freed_d;
      total_q       <= total_d;
      outstanding_q <= outstanding_d;
      load_slot_q   <= load_slot_d;
      load_bidx_q   <= load_bidx_d;
      batch_valid_q <= batch_valid_d;
      layer_done_q  <= layer_done_d;
      err_q         <= err_d;
    end
  end

  assign bus.load_req    = outstanding_q;
  assign bus.load_slot   = load_slot_q;
  assign bus.load_bidx   = load_bidx_q;
  assign bus.batch_valid = batch_valid_q;
  assign bus.rd_slot     = rd_ptr_q;
  assign layer_done      = layer_done_q;
  assign err_underflow   = err_q;

endmodule

// File: tb/tb_ifmap_batch_ctrl.sv
// Self-checking bench for ifmap_batch_ctrl: directed scenarios plus a
// randomized run, all compared against a queue-based model of the slot ring.
module tb_ifmap_batch_ctrl;
  import ifmap_batch_pkg::*;

  localparam int N  = 2;
  localparam int BW = 4;
  localparam int L1 = 8;
  localparam int L2 = 1;
  localparam int L3 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  layer_type_e layer_type_in = LAYER1;
  logic        layer_done;
  logic        err_underflow;

  ifmap_batch_if #(.NUM_SLOTS(N), .BIDX_W(BW)) bus ();

  ifmap_batch_ctrl #(
    .NUM_SLOTS(N), .L1_BATCHES(L1), .L2_BATCHES(L2), .L3_BATCHES(L3), .BIDX_W(BW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .layer_type_in (layer_type_in),
    .bus           (bus),
    .layer_done    (layer_done),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the ring is a FIFO of loaded batch indices; slot
  // numbers follow from the load/free counts modulo the ring size.
  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_e;
  mstate_e m_state;
  int      m_total, m_fetched, m_freed, m_bidx, m_slot;
  bit      m_out, m_ld, m_err;
  int      m_q[$];

  function automatic int batches(input layer_type_e t);
    case (t)
      LAYER2:  return L2;
      LAYER3:  return L3;
      default: return L1;
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_total = 0; m_fetched = 0; m_freed = 0;
    m_bidx = 0; m_slot = 0; m_out = 0; m_ld = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit s, input layer_type_e t, input bit d, input bit f);
    mstate_e prev = m_state;
    bit can_issue, fok;
    m_ld = 0;
    if (s) begin
      m_state = M_RUN; m_total = batches(t); m_fetched = 0; m_freed = 0;
      m_q.delete(); m_err = 0; m_out = (m_total > 0); m_bidx = 0; m_slot = 0;
    end else begin
      can_issue = (prev == M_RUN) && !m_out && (m_q.size() < N) && (m_fetched < m_total);
      fok = f && (prev == M_RUN) && (m_q.size() > 0);
      if (m_out && d) begin
        m_q.push_back(m_fetched); m_fetched++; m_out = 0;
      end
      if (fok) begin
        void'(m_q.pop_front()); m_freed++;
      end else if (f) begin
        m_err = 1;
      end
      if (prev == M_RUN) begin
        if (fok && m_freed == m_total) begin
          m_state = M_DONE; m_ld = 1;
        end else if (can_issue) begin
          m_out = 1; m_bidx = m_fetched; m_slot = m_fetched % N;
        end
      end else if (prev == M_DONE) begin
        m_state = M_IDLE;
      end
    end
  endtask

  // One clock: inputs applied now, sampled at the next edge, outputs read 1 ns later.
  task automatic cycle(input bit s, input layer_type_e t, input bit d, input bit f);
    start = s; layer_type_in = t; bus.load_done = d; bus.free_ifmap_buffer = f;
    @(posedge clk);
    model_step(s, t, d, f);
    #1;
    start = 1'b0; bus.load_done = 1'b0; bus.free_ifmap_buffer = 1'b0;
  endtask

  task automatic test_reset();
    int highs;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.load_req, bus.load_slot, bus.load_bidx, bus.batch_valid, bus.rd_slot, layer_done, err_underflow} !== '0) begin
      failures++;
      $display("FAIL reset_values: got %b required all zero",
               {bus.load_req, bus.load_slot, bus.load_bidx, bus.batch_valid, bus.rd_slot, layer_done, err_underflow});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    // Mid-run: one batch loaded, second request in flight.
    cycle(1, LAYER1, 0, 0);
    cycle(0, LAYER1, 1, 0);
    cycle(0, LAYER1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.load_req, bus.load_slot, bus.load_bidx, bus.batch_valid, bus.rd_slot, layer_done, err_underflow} !== '0) begin
      failures++;
      $display("FAIL async_reset_mid_run: got %b required all zero",
               {bus.load_req, bus.load_slot, bus.load_bidx, bus.batch_valid, bus.rd_slot, layer_done, err_underflow});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, LAYER1, 0, 0);
      if (bus.load_req !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("FAIL no_req_after_reset: got %0d cycles with load_req required 0", highs);
    end
  endtask

  task automatic test_layer3();
    int pulses;
    cycle(1, LAYER3, 0, 0);
    checks++;
    if ({bus.load_req, bus.load_bidx, bus.load_slot} !== {1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL l3_first_req: got req=%0b bidx=%0d slot=%0d required req=1 bidx=0 slot=0",
               bus.load_req, bus.load_bidx, bus.load_slot);
    end
    cycle(0, LAYER3, 0, 0);
    cycle(0, LAYER3, 0, 0);
    cycle(0, LAYER3, 1, 0);
    checks++;
    if ({bus.load_req, bus.batch_valid, bus.rd_slot} !== {1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL l3_loaded: got req=%0b valid=%0b rd_slot=%0d required req=0 valid=1 rd_slot=0",
               bus.load_req, bus.batch_valid, bus.rd_slot);
    end
    cycle(0, LAYER3, 0, 1);
    pulses = int'(layer_done);
    for (int i = 0; i < 4; i++) begin
      cycle(0, LAYER3, 0, 0);
      pulses += int'(layer_done);
    end
    checks++;
    if (pulses != 1 || err_underflow !== 1'b0 || bus.batch_valid !== 1'b0) begin
      failures++;
      $display("FAIL l3_done: got pulses=%0d err=%0b valid=%0b required pulses=1 err=0 valid=0",
               pulses, err_underflow, bus.batch_valid);
    end
    // Free with nothing running is an underflow.
    cycle(0, LAYER3, 0, 1);
    checks++;
    if (err_underflow !== 1'b1) begin
      failures++;
      $display("FAIL free_in_idle: got err=%0b required 1", err_underflow);
    end
  endtask

  task automatic test_backpressure();
    int highs, pulses, bad, exp_next;
    bit prev_req;
    cycle(1, LAYER1, 0, 0);
    cycle(0, LAYER1, 1, 0);
    cycle(0, LAYER1, 0, 0);
    checks++;
    if ({bus.load_req, bus.load_bidx, bus.load_slot} !== {1'b1, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL bp_second_req: got req=%0b bidx=%0d slot=%0d required req=1 bidx=1 slot=1",
               bus.load_req, bus.load_bidx, bus.load_slot);
    end
    cycle(0, LAYER1, 1, 0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, LAYER1, 0, 0);
      if (bus.load_req !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("FAIL bp_blocked: got %0d cycles with load_req required 0", highs);
    end
    cycle(0, LAYER1, 0, 1);
    checks++;
    if ({bus.load_req, bus.batch_valid, bus.rd_slot} !== {1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL bp_after_free: got req=%0b valid=%0b rd_slot=%0d required req=0 valid=1 rd_slot=1",
               bus.load_req, bus.batch_valid, bus.rd_slot);
    end
    cycle(0, LAYER1, 0, 0);
    checks++;
    if ({bus.load_req, bus.load_bidx, bus.load_slot} !== {1'b1, 4'd2, 1'b0}) begin
      failures++;
      $display("FAIL bp_released: got req=%0b bidx=%0d slot=%0d required req=1 bidx=2 slot=0",
               bus.load_req, bus.load_bidx, bus.load_slot);
    end
    pulses = 0; bad = 0; exp_next = 3; prev_req = 1'b1;
    for (int i = 0; i < 300 && m_state != M_IDLE; i++) begin
      cycle(0, LAYER1, m_out && (i % 2 == 1), (m_q.size() > 0) && (i % 3 == 0));
      pulses += int'(layer_done);
      if (bus.load_req && !prev_req) begin
        if (bus.load_bidx !== BW'(exp_next)) bad++;
        exp_next++;
      end
      prev_req = bus.load_req;
    end
    cycle(0, LAYER1, 0, 0);
    pulses += int'(layer_done);
    checks++;
    if (pulses != 1 || bad != 0 || exp_next != L1 || err_underflow !== 1'b0) begin
      failures++;
      $display("FAIL l1_full_run: got pulses=%0d bidx_errs=%0d loads=%0d err=%0b required pulses=1 bidx_errs=0 loads=%0d err=0",
               pulses, bad, exp_next, err_underflow, L1);
    end
  endtask

  task automatic test_simultaneous();
    cycle(1, LAYER1, 0, 0);
    cycle(0, LAYER1, 1, 0);
    cycle(0, LAYER1, 0, 0);
    cycle(0, LAYER1, 1, 1);
    checks++;
    if ({bus.load_req, bus.batch_valid, bus.rd_slot, err_underflow} !== {1'b0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL simul_edge: got req=%0b valid=%0b rd_slot=%0d err=%0b required req=0 valid=1 rd_slot=1 err=0",
               bus.load_req, bus.batch_valid, bus.rd_slot, err_underflow);
    end
    cycle(0, LAYER1, 0, 0);
    checks++;
    if ({bus.load_req, bus.load_bidx, bus.load_slot} !== {1'b1, 4'd2, 1'b0}) begin
      failures++;
      $display("FAIL simul_next_req: got req=%0b bidx=%0d slot=%0d required req=1 bidx=2 slot=0",
               bus.load_req, bus.load_bidx, bus.load_slot);
    end
    cycle(0, LAYER1, 0, 1);
    checks++;
    if ({bus.batch_valid, bus.rd_slot, err_underflow} !== {1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL simul_second_free: got valid=%0b rd_slot=%0d err=%0b required valid=0 rd_slot=0 err=0",
               bus.batch_valid, bus.rd_slot, err_underflow);
    end
  endtask

  task automatic test_underflow();
    cycle(1, LAYER1, 0, 0);
    cycle(0, LAYER1, 0, 1);
    checks++;
    if ({err_underflow, bus.batch_valid, bus.rd_slot, bus.load_req, bus.load_bidx} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL underflow_set: got err=%0b valid=%0b rd_slot=%0d req=%0b bidx=%0d required err=1 valid=0 rd_slot=0 req=1 bidx=0",
               err_underflow, bus.batch_valid, bus.rd_slot, bus.load_req, bus.load_bidx);
    end
    repeat (3) cycle(0, LAYER1, 0, 0);
    checks++;
    if (err_underflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sticky: got err=%0b required 1", err_underflow);
    end
    cycle(1, LAYER3, 0, 0);
    checks++;
    if (err_underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_cleared: got err=%0b required 0", err_underflow);
    end
  endtask

  task automatic test_restart();
    cycle(1, LAYER1, 0, 0);
    cycle(0, LAYER1, 0, 0);
    cycle(1, LAYER2, 1, 0);
    checks++;
    if ({bus.load_req, bus.load_bidx, bus.load_slot, bus.batch_valid} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL restart_req: got req=%0b bidx=%0d slot=%0d valid=%0b required req=1 bidx=0 slot=0 valid=0",
               bus.load_req, bus.load_bidx, bus.load_slot, bus.batch_valid);
    end
    cycle(0, LAYER2, 1, 0);
    checks++;
    if ({bus.load_req, bus.batch_valid} !== {1'b0, 1'b1}) begin
      failures++;
      $display("FAIL restart_loaded: got req=%0b valid=%0b required req=0 valid=1", bus.load_req, bus.batch_valid);
    end
    cycle(0, LAYER2, 0, 1);
    checks++;
    if (layer_done !== 1'b1) begin
      failures++;
      $display("FAIL restart_done: got layer_done=%0b required 1", layer_done);
    end
    cycle(0, LAYER2, 0, 0);
    checks++;
    if ({layer_done, bus.load_req, err_underflow} !== 3'b000) begin
      failures++;
      $display("FAIL restart_after_done: got done=%0b req=%0b err=%0b required 0 0 0",
               layer_done, bus.load_req, err_underflow);
    end
  endtask

  task automatic test_random();
    int wait_cnt = 0;
    int lat = 1;
    int bad = 0;
    bit s, d, f;
    layer_type_e t;
    for (int i = 0; i < 800; i++) begin
      t = layer_type_e'($urandom_range(0, 2));
      s = ($urandom_range(0, 199) == 0) || (m_state == M_IDLE && $urandom_range(0, 3) == 0);
      d = 1'b0;
      if (m_out) begin
        if (wait_cnt >= lat) begin
          d = 1'b1; wait_cnt = 0; lat = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end else if ($urandom_range(0, 30) == 0) begin
        d = 1'b1;
      end
      f = ((m_q.size() > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 60) == 0);
      if (s) wait_cnt = 0;
      cycle(s, t, d, f);
      checks++;
      if ({bus.load_req, bus.batch_valid, bus.rd_slot, layer_done, err_underflow} !==
          {m_out, m_q.size() > 0, 1'(m_freed % N), m_ld, m_err} ||
          (m_out && {bus.load_bidx, bus.load_slot} !== {BW'(m_bidx), 1'(m_slot)})) begin
        failures++;
        if (bad < 10)
          $display("FAIL random_cycle_%0d: got req=%0b valid=%0b rd=%0d done=%0b err=%0b bidx=%0d slot=%0d required req=%0b valid=%0b rd=%0d done=%0b err=%0b bidx=%0d slot=%0d",
                   i, bus.load_req, bus.batch_valid, bus.rd_slot, layer_done, err_underflow, bus.load_bidx, bus.load_slot,
                   m_out, m_q.size() > 0, m_freed % N, m_ld, m_err, m_bidx, m_slot);
        bad++;
      end
    end
  endtask

  initial begin
    bus.load_done = 1'b0;
    bus.free_ifmap_buffer = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_layer3();
    test_backpressure();
    test_simultaneous();
    test_underflow();
    test_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
